// File: rtl/cpu_pkg.sv
// Types and constants for the instruction-fetch stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus plus the instruction hand-off to decode.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;

  // The fetch unit masters the memory bus and sources instructions to decode.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem handshake FSM and the
// registered instruction slot presented to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             misalign_fault,
  fetch_unit_if.master     bus
);

  fetch_state_e     state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic             kill, kill_n;
  logic             valid_q, valid_n;
  logic [WIDTH-1:0] instr_q, instr_n;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_n;
  logic             fault_q, fault_n;
  logic             misaligned;
  logic             outstanding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      instr_pc_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      kill       <= kill_n;
      valid_q    <= valid_n;
      instr_q    <= instr_n;
      instr_pc_q <= instr_pc_n;
      fault_q    <= fault_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    kill_n      = kill;
    valid_n     = valid_q;
    instr_n     = instr_q;
    instr_pc_n  = instr_pc_q;
    fault_n     = fault_q;
    misaligned  = |redirect_pc[1:0];
    // A transaction is still owed a response if granted now or waiting without data.
    outstanding = ((state == WAIT) && !bus.imem_rvalid) ||
                  ((state == REQ) && bus.imem_gnt);

    if (redirect_valid) begin
      valid_n = 1'b0;
      instr_n = NOP;
      if (misaligned) begin
        fault_n = 1'b1;
      end else begin
        fault_n = 1'b0;
        pc_n    = redirect_pc;
      end
      if (outstanding) begin
        kill_n  = 1'b1;
        state_n = WAIT;
      end else if (state == WAIT) begin
        kill_n  = 1'b0;
        state_n = misaligned ? FAULT : REQ;
      end else if (misaligned) begin
        state_n = FAULT;
      end else begin
        state_n = en ? REQ : IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (en) state_n = REQ;
        end
        REQ: begin
          if (bus.imem_gnt) state_n = WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (kill) begin
              // Response belongs to a flushed fetch; a pending fault parks here.
              kill_n  = 1'b0;
              state_n = fault_q ? FAULT : REQ;
            end else begin
              instr_n    = bus.imem_rdata;
              instr_pc_n = pc;
              valid_n    = 1'b1;
              pc_n       = pc + WIDTH'(PC_STEP);
              state_n    = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            valid_n = 1'b0;
            instr_n = NOP;
            state_n = en ? REQ : IDLE;
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign misalign_fault  = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests, expected
// request addresses and delivered instructions are queued and checked on handshake.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_fault;

  fetch_unit_if #(.WIDTH(WIDTH)) bus ();

  fetch_unit #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_fault (misalign_fault),
    .bus            (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;
  int cycle       = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];
  int          deliver_cyc_q[$];

  int          rv_delay      = 0;
  logic        override_on   = 1'b0;
  logic [31:0] override_addr = '0;
  logic [31:0] override_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return (addr ^ 32'hA5A5_0000) | 32'h3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Memory model: grant in the request cycle, data rv_delay cycles after the grant edge.
  initial begin
    logic        pending;
    logic [31:0] paddr;
    int          rv_wait;
    pending = 1'b0;
    paddr   = '0;
    rv_wait = 0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (pending) begin
        if (rv_wait == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = (override_on && paddr == override_addr) ? override_data
                                                                    : mem_word(paddr);
          pending = 1'b0;
        end else begin
          rv_wait--;
        end
      end else if (bus.imem_req) begin
        bus.imem_gnt = 1'b1;
        paddr   = bus.imem_addr;
        pending = 1'b1;
        rv_wait = rv_delay;
      end
    end
  end

  // Monitor: samples just before each rising edge, when the handshakes resolve.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.instr_valid && bus.instr_ready) begin
        checkOutput("instr_expected", 32'(exp_instr_q.size() > 0), 32'd1);
        if (exp_instr_q.size() > 0) begin
          checkOutput("instr", bus.instr, exp_instr_q.pop_front());
          checkOutput("instr_pc", bus.instr_pc, exp_pc_q.pop_front());
        end
        delivered++;
        deliver_cyc_q.push_back(cycle);
      end
      if (!rst && bus.imem_req && bus.imem_gnt) begin
        checkOutput("req_expected", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) checkOutput("imem_addr", bus.imem_addr, exp_addr_q.pop_front());
      end
    end
  end

  task automatic expectFetch(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(data);
    exp_pc_q.push_back(addr);
  endtask

  task automatic applyStimulus(input logic rdv, input logic [31:0] rpc, input logic run);
    redirect_valid = rdv;
    redirect_pc    = rpc;
    en             = run;
  endtask

  task automatic waitReq();
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_seen", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic waitValid();
    int n = 0;
    while (!bus.instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("valid_seen", 32'(bus.instr_valid), 32'd1);
  endtask

  // Run until target deliveries, dropping en during the last hold so the unit parks in IDLE.
  task automatic finishFetches(input int target);
    int n = 0;
    while (delivered < target && n < 200) begin
      @(negedge clk);
      if (bus.instr_valid && delivered == target - 1) en = 1'b0;
      n++;
    end
    checkOutput("delivered", 32'(delivered), 32'(target));
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_addr", bus.imem_addr, DEFAULT_RESET_PC);
    checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_instr", bus.instr, NOP_INSTR);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
    checkOutput("rst_fault", 32'(misalign_fault), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] zero-wait streaming from reset PC");
    for (int i = 0; i < 3; i++) expectFetch(32'(4 * i), mem_word(32'(4 * i)));
    en = 1'b1;
    finishFetches(3);
    checkOutput("throughput_gap", 32'(deliver_cyc_q[2] - deliver_cyc_q[0]), 32'd6);

    $display("[TB] decode stall holds the instruction");
    expectFetch(32'hC, mem_word(32'hC));
    expectFetch(32'h10, mem_word(32'h10));
    bus.instr_ready = 1'b0;
    en = 1'b1;
    waitValid();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("stall_instr", bus.instr, mem_word(32'hC));
      checkOutput("stall_pc", bus.instr_pc, 32'hC);
      checkOutput("stall_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
    end
    bus.instr_ready = 1'b1;
    finishFetches(delivered + 2);
    checkOutput("consumed_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("consumed_instr", bus.instr, NOP_INSTR);

    $display("[TB] redirect while waiting flushes the response");
    exp_addr_q.push_back(32'h14);
    expectFetch(32'h100, mem_word(32'h100));
    override_on   = 1'b1;
    override_addr = 32'h14;
    override_data = 32'hDEAD_BEEF;
    rv_delay      = 2;
    en = 1'b1;
    waitReq();
    @(negedge clk);
    applyStimulus(1'b1, 32'h100, 1'b1);
    rv_delay = 0;
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    n = 0;
    while (n < 20) begin
      #1;
      if (bus.imem_rvalid) break;
      @(negedge clk);
      n++;
    end
    checkOutput("late_rvalid_seen", 32'(bus.imem_rvalid), 32'd1);
    @(negedge clk);
    checkOutput("flush_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("flush_instr", bus.instr, NOP_INSTR);
    checkOutput("flush_req", 32'(bus.imem_req), 32'd1);
    checkOutput("flush_addr", bus.imem_addr, 32'h100);
    finishFetches(delivered + 1);
    override_on = 1'b0;

    $display("[TB] misaligned redirect faults until an aligned redirect");
    applyStimulus(1'b1, 32'h102, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fault_set", 32'(misalign_fault), 32'd1);
    checkOutput("fault_pc_kept", bus.imem_addr, 32'h104);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("fault_no_req", 32'(bus.imem_req), 32'd0);
      checkOutput("fault_sticky", 32'(misalign_fault), 32'd1);
    end
    expectFetch(32'h200, mem_word(32'h200));
    applyStimulus(1'b1, 32'h200, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fault_cleared", 32'(misalign_fault), 32'd0);
    checkOutput("resume_req", 32'(bus.imem_req), 32'd1);
    checkOutput("resume_addr", bus.imem_addr, 32'h200);
    finishFetches(delivered + 1);

    $display("[TB] PC wraps at the top of the address space");
    expectFetch(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    finishFetches(delivered + 1);
    checkOutput("wrap_addr", bus.imem_addr, 32'h0);
    checkOutput("wrap_fault", 32'(misalign_fault), 32'd0);

    $display("[TB] reset in the middle of a transaction");
    exp_addr_q.push_back(32'h300);
    rv_delay = 3;
    applyStimulus(1'b1, 32'h300, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1);
    waitReq();
    @(negedge clk);
    en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_req", 32'(bus.imem_req), 32'd0);
    checkOutput("midrst_addr", bus.imem_addr, DEFAULT_RESET_PC);
    checkOutput("midrst_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("midrst_instr", bus.instr, NOP_INSTR);
    checkOutput("midrst_instr_pc", bus.instr_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rv_delay = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("postrst_valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("postrst_req", 32'(bus.imem_req), 32'd0);
    end

    checkOutput("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
